snake_step_ctrl: RTL and testbench
==================================

// Module: snake_step_ctrl
// PURPOSE
//  Game-tick scheduler that sequences snake head movement. Divides clk into move ticks.
//  On each tick it samples the latched 3-bit direction code and computes the next head
//  coordinate with playfield wrap-around. It then hands the step to the body/collision
//  logic over a valid/ready handshake and tracks run/pause/dead game state.
//  Sits between the direction-input register and the body memory / collision checker.
// PARAMETERS
//  GRID_W    16         playfield width in cells (x range 0..GRID_W-1)
//  GRID_H    12         playfield height in cells (y range 0..GRID_H-1)
//  XW        4          head_x width, >= clog2(GRID_W)
//  YW        4          head_y width, >= clog2(GRID_H)
//  TICK_DIV  5000000    unpaused RUN cycles per move tick (>= 2)
//  CNT_W     23         tick counter width, >= clog2(TICK_DIV)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high reset
//  start       in   1   level; begins or restarts a game
//  pause       in   1   level; freezes tick counter while in RUN
//  dir         in   3   direction code: 000 right, 001 left, 010 up, 011 down, 1xx hold
//  step_ready  in   1   body/collision logic accepts the current step
//  collide     in   1   collision result for the offered step; sampled only on handshake
//  step_valid  out  1   a new head position is offered
//  step_dir    out  3   direction applied for the offered step
//  head_x      out  XW  current head x
//  head_y      out  YW  current head y
//  state       out  2   00 IDLE, 01 RUN, 10 WAIT, 11 DEAD
//  step_count  out  16  accepted non-colliding steps, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset, one clock edge:
//      state=IDLE, head_x=GRID_W/2, head_y=GRID_H/2, step_valid=0, step_dir=000,
//      step_count=0, tick counter=0. Reset overrides every other input in any state.
//  - All outputs are registered. Screen axes: up decrements y, down increments y.
//  - IDLE: start=1 -> RUN with counter=0. start beats pause if both are high.
//  - RUN:
//      pause=1 holds the counter, otherwise the counter increments.
//      On an unpaused cycle with counter==TICK_DIV-1, at that edge:
//        counter<=0; step_dir<=dir (keep the old step_dir if dir[2]=1);
//        head moves one cell per the new step_dir; step_valid<=1; state<=WAIT.
//      First step_valid rises exactly TICK_DIV unpaused cycles after entering RUN.
//  - Wrap-around:
//      right at x=GRID_W-1 -> 0; left at x=0 -> GRID_W-1;
//      up at y=0 -> GRID_H-1; down at y=GRID_H-1 -> 0.
//  - WAIT:
//      step_valid, head_x/y and step_dir are held stable; counter is frozen; pause and dir
//      are ignored. On step_valid&&step_ready:
//        collide=1 -> DEAD;
//        collide=0 -> step_count+1 (saturating), then RUN.
//      In both cases step_valid=0 from the next cycle.
//      With ready tied high a WAIT lasts 1 cycle, so the step period is TICK_DIV+1.
//  - DEAD:
//      step_valid=0; head, step_dir and step_count are frozen.
//      start=1 -> head to centre, step_count=0, counter=0, step_dir=000, state=RUN.
//  - start is ignored in RUN and WAIT. No reversal filtering; the upstream register
//    owns that.
// TESTING  (GRID_W=16, GRID_H=12, TICK_DIV=4, ready tied 1, collide=0 unless noted)
//  1. reset, start 1 cycle, dir=000 -> step_valid on 4th cycle after RUN entry with
//     head=(9,6); steps every 5 cycles; step_count=3 after 3 steps.
//  2. dir=001 from (8,6), 9 steps -> x sequence ...1,0,15; final head=(15,6),
//     step_dir=001.
//  3. dir=010 from (8,6), 7 steps -> final head=(8,11); then dir=100 -> step_dir stays
//     010, next head=(8,10).
//  4. step_ready=0 for 10 cycles in WAIT -> step_valid held, head stable, count
//     unchanged; ready=1 -> count+1, state=RUN next cycle.
//  5. collide=1 with ready=1 -> state=DEAD, step_valid=0 next cycle, head frozen;
//     start -> RUN, head=(8,6), step_count=0.
//  6. pause high 6 cycles mid-count -> step_valid delayed by exactly 6 cycles;
//     reset asserted during WAIT -> IDLE and all reset values after one edge.

Source files
------------

// File: rtl/snake_step_ctrl_if.sv
// Step handshake between the head scheduler and the body/collision logic.
// The master offers a new head position and direction; the slave accepts it and
// returns the collision result for that step.
interface snake_step_ctrl_if #(
    parameter int unsigned XW = 4,
    parameter int unsigned YW = 4
);
    logic          step_valid;
    logic          step_ready;
    logic          collide;
    logic [2:0]    step_dir;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;

    modport master (
        output step_valid,
        output step_dir,
        output head_x,
        output head_y,
        input  step_ready,
        input  collide
    );

    modport slave (
        input  step_valid,
        input  step_dir,
        input  head_x,
        input  head_y,
        output step_ready,
        output collide
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake head step scheduler: divides clk into move ticks, advances the head with
// playfield wrap-around, offers each step over valid/ready and tracks game state.
module snake_step_ctrl #(
    parameter int unsigned GRID_W   = 16,
    parameter int unsigned GRID_H   = 12,
    parameter int unsigned XW       = 4,
    parameter int unsigned YW       = 4,
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned CNT_W    = 23
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic [2:0]          dir,
    snake_step_ctrl_if.master   step,
    output logic [1:0]          state,
    output logic [15:0]         step_count
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StWait = 2'b10,
        StDead = 2'b11
    } state_e;

    localparam logic [XW-1:0]    XMax    = XW'(GRID_W - 1);
    localparam logic [YW-1:0]    YMax    = YW'(GRID_H - 1);
    localparam logic [XW-1:0]    XCentre = XW'(GRID_W / 2);
    localparam logic [YW-1:0]    YCentre = YW'(GRID_H / 2);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic [2:0]    step_dir_q, step_dir_d;
    logic          valid_q, valid_d;
    logic [15:0]   count_q, count_d;

    // Direction for a tick: codes with bit 2 set keep the previous heading.
    logic [2:0]    mv_dir;
    logic [XW-1:0] mv_x;
    logic [YW-1:0] mv_y;

    // Next head position one cell along mv_dir, wrapping at the playfield edges.
    always_comb begin
        mv_dir = dir[2] ? step_dir_q : dir;
        mv_x   = head_x_q;
        mv_y   = head_y_q;
        case (mv_dir[1:0])
            2'b00:   mv_x = (head_x_q == XMax) ? '0 : head_x_q + XW'(1);
            2'b01:   mv_x = (head_x_q == '0) ? XMax : head_x_q - XW'(1);
            2'b10:   mv_y = (head_y_q == '0) ? YMax : head_y_q - YW'(1);
            default: mv_y = (head_y_q == YMax) ? '0 : head_y_q + YW'(1);
        endcase
    end

    // Game FSM and datapath next-state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        step_dir_d = step_dir_q;
        valid_d    = valid_q;
        count_d    = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (!pause) begin
                    if (cnt_q == CntLast) begin
                        cnt_d      = '0;
                        step_dir_d = mv_dir;
                        head_x_d   = mv_x;
                        head_y_d   = mv_y;
                        valid_d    = 1'b1;
                        state_d    = StWait;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StWait: begin
                if (valid_q && step.step_ready) begin
                    valid_d = 1'b0;
                    if (step.collide) begin
                        state_d = StDead;
                    end else begin
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                        state_d = StRun;
                    end
                end
            end
            StDead: begin
                valid_d = 1'b0;
                if (start) begin
                    head_x_d   = XCentre;
                    head_y_d   = YCentre;
                    count_d    = '0;
                    cnt_d      = '0;
                    step_dir_d = 3'b000;
                    state_d    = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            head_x_q   <= XCentre;
            head_y_q   <= YCentre;
            step_dir_q <= 3'b000;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            step_dir_q <= step_dir_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign step.step_valid = valid_q;
    assign step.step_dir   = step_dir_q;
    assign step.head_x     = head_x_q;
    assign step.head_y     = head_y_q;
    assign state           = state_q;
    assign step_count      = count_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with a 16x12 grid and a 4-cycle tick.
module tb_snake_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [2:0]  dir;
    logic [1:0]  state;
    logic [15:0] step_count;

    int checks   = 0;
    int failures = 0;

    snake_step_ctrl_if #(.XW(4), .YW(4)) sif ();

    snake_step_ctrl #(
        .GRID_W   (16),
        .GRID_H   (12),
        .XW       (4),
        .YW       (4),
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .dir        (dir),
        .step       (sif.master),
        .state      (state),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       pause;
        logic [2:0] dir;
        logic       ready;
        logic       collide;
        logic       exp_valid;
        int         exp_x;
        int         exp_y;
        int         exp_state;
        int         exp_count;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Clock until step_valid is seen, bounded.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (sif.step_valid !== 1'b1 && n < 40);
        if (sif.step_valid !== 1'b1) check({name, " timeout"}, 32'(sif.step_valid), 32'd1);
    endtask

    task automatic check_head(input string name, input int x, input int y);
        check({name, " x"}, 32'(sif.head_x), 32'(x));
        check({name, " y"}, 32'(sif.head_y), 32'(y));
    endtask

    initial begin
        int k;

        // start, pause, dir, ready, collide | valid, x, y, state, count
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  8, 6, 1, 0};
        tbl[1]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  8, 6, 1, 0};
        tbl[2]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  8, 6, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  8, 6, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1,  9, 6, 2, 0};
        tbl[5]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  9, 6, 1, 1};
        tbl[6]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  9, 6, 1, 1};
        tbl[7]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  9, 6, 1, 1};
        tbl[8]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,  9, 6, 1, 1};
        tbl[9]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 10, 6, 2, 1};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 10, 6, 1, 2};
        tbl[11] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 10, 6, 1, 2};
        tbl[12] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 10, 6, 1, 2};
        tbl[13] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 10, 6, 1, 2};
        tbl[14] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 11, 6, 2, 2};
        tbl[15] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 11, 6, 1, 3};

        reset          = 1'b1;
        start          = 1'b0;
        pause          = 1'b0;
        dir            = 3'b000;
        sif.step_ready = 1'b1;
        sif.collide    = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst state", 32'(state), 32'd0);
        check_head("rst head", 8, 6);
        check("rst valid", 32'(sif.step_valid), 32'd0);
        check("rst dir", 32'(sif.step_dir), 32'd0);
        check("rst count", 32'(step_count), 32'd0);
        reset = 1'b0;

        // Test 1: table-driven start and three rightward steps
        for (int i = 0; i < 16; i++) begin
            start          = tbl[i].start;
            pause          = tbl[i].pause;
            dir            = tbl[i].dir;
            sif.step_ready = tbl[i].ready;
            sif.collide    = tbl[i].collide;
            tick();
            check($sformatf("vec%0d valid", i), 32'(sif.step_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d x", i), 32'(sif.head_x), 32'(tbl[i].exp_x));
            check($sformatf("vec%0d y", i), 32'(sif.head_y), 32'(tbl[i].exp_y));
            check($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].exp_state));
            check($sformatf("vec%0d count", i), 32'(step_count), 32'(tbl[i].exp_count));
        end
        start = 1'b0;

        // Test 2: left with wrap from x=0 to 15
        dir = 3'b001;
        do_start();
        for (int s = 1; s <= 9; s++) begin
            wait_valid($sformatf("left%0d", s));
            check_head($sformatf("left%0d", s), (8 + 16 - s) % 16, 6);
            tick();
        end
        check_head("left final", 15, 6);
        check("left dir", 32'(sif.step_dir), 32'd1);

        // Test 3: up with wrap from y=0 to 11, then hold code keeps heading
        dir = 3'b010;
        do_start();
        for (int s = 1; s <= 7; s++) begin
            wait_valid($sformatf("up%0d", s));
            check_head($sformatf("up%0d", s), 8, (6 + 12 - s) % 12);
            tick();
        end
        dir = 3'b100;
        wait_valid("hold");
        check("hold dir", 32'(sif.step_dir), 32'd2);
        check_head("hold", 8, 10);
        tick();

        // Test 4: backpressure holds the offered step
        dir            = 3'b000;
        sif.step_ready = 1'b0;
        do_start();
        wait_valid("bp");
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp%0d valid", c), 32'(sif.step_valid), 32'd1);
            check_head($sformatf("bp%0d", c), 9, 6);
            check($sformatf("bp%0d state", c), 32'(state), 32'd2);
            check($sformatf("bp%0d count", c), 32'(step_count), 32'd0);
        end
        sif.step_ready = 1'b1;
        tick();
        check("bp count", 32'(step_count), 32'd1);
        check("bp state", 32'(state), 32'd1);
        check("bp valid", 32'(sif.step_valid), 32'd0);

        // Test 5: collision kills, start restarts from centre
        sif.collide = 1'b1;
        wait_valid("col");
        tick();
        sif.collide = 1'b0;
        check("col state", 32'(state), 32'd3);
        check("col valid", 32'(sif.step_valid), 32'd0);
        check_head("col", 10, 6);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("dead%0d state", c), 32'(state), 32'd3);
            check_head($sformatf("dead%0d", c), 10, 6);
            check($sformatf("dead%0d count", c), 32'(step_count), 32'd1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart state", 32'(state), 32'd1);
        check_head("restart", 8, 6);
        check("restart count", 32'(step_count), 32'd0);
        check("restart dir", 32'(sif.step_dir), 32'd0);

        // Test 6: six paused cycles delay the step by six
        do_start();
        wait_valid("pre");
        tick();
        k = 0;
        while (sif.step_valid !== 1'b1 && k < 30) begin
            k++;
            pause = (k >= 2 && k <= 7);
            tick();
        end
        pause = 1'b0;
        check("pause delay", 32'(k), 32'd10);
        check("pause state", 32'(state), 32'd2);
        check("pause count", 32'(step_count), 32'd1);

        // Reset during WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrst state", 32'(state), 32'd0);
        check_head("wrst", 8, 6);
        check("wrst valid", 32'(sif.step_valid), 32'd0);
        check("wrst dir", 32'(sif.step_dir), 32'd0);
        check("wrst count", 32'(step_count), 32'd0);

        // start beats pause in IDLE
        start = 1'b1;
        pause = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b0;
        check("startpause state", 32'(state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
